// File: rtl/sd_pkg.sv
// sd_pkg -- shared definitions for the SD command-line sequencer.
//
// Contents:
//   sd_state_e   : sequencer FSM states
//   sd_rsp_e     : response-type codes carried in cmd_reg[1:0]
//   CMD_*        : bit positions of the fields inside the command register
//   *_BITS       : frame lengths on the CMD line
//   crc7_next()  : one serial step of the CRC7 (x^7 + x^3 + 1)
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX       = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_RX       = 3'd3,
    ST_CHECK    = 3'd4,
    ST_DONE     = 3'd5
  } sd_state_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_R136 = 2'b01,
    RSP_R48  = 2'b10,
    RSP_R48B = 2'b11
  } sd_rsp_e;

  // Command register field positions
  localparam int CMD_IDX_MSB = 13;
  localparam int CMD_IDX_LSB = 8;
  localparam int CMD_IDX_CHK = 4;
  localparam int CMD_CRC_CHK = 3;
  localparam int CMD_RSP_MSB = 1;
  localparam int CMD_RSP_LSB = 0;

  // Frame lengths in bits
  localparam int TX_BITS     = 48;
  localparam int TX_CRC_BITS = 40;
  localparam int R48_BITS    = 48;
  localparam int R136_BITS   = 136;

  // Shift left, feedback into x^0 and x^3.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7 -- serial CRC7 generator/checker, one bit per enabled cycle.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset (CRC cleared)
//   clr_i  : synchronous clear to 0, wins over en_i
//   en_i   : shift bit_i into the CRC this cycle
//   bit_i  : serial data bit
//   crc_o  : current CRC value
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = crc7_next(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq -- SD host CMD-line sequencer: serialises a 48-bit command,
// waits for and receives the 48/136-bit response, checks it and reports.
//
// Parameters:
//   NCR_MAX : bit strobes allowed between command end bit and response start bit
//   STB_DIV : clk cycles per CMD-line bit strobe (2..255)
//
// Ports:
//   clk, ex_resetn (async, active low), soft_rst_cmd (sync command abort)
//   cmd_start/cmd_reg/arg_reg : command issue (register write pulse + values)
//   sd_cmd_i / sd_cmd_o / sd_cmd_oe : CMD line
//   cmd_inhibit      : sequencer busy
//   resp0_d..resp3_d : response words, valid with resp_we
//   cmd_complete     : one-cycle completion pulse, err_flags valid with it
//   err_flags        : {end-bit, index, CRC, timeout}
//
// Build option: define SD_CMD_RESP_CRC_CHK_EN to include the response CRC7
// checker; without it the CRC error flag is always 0.
module sd_cmd_seq
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 64,
  parameter int STB_DIV = 4
) (
  input  logic        clk,
  input  logic        ex_resetn,
  input  logic        soft_rst_cmd,
  input  logic        cmd_start,
  input  logic [15:0] cmd_reg,
  input  logic [31:0] arg_reg,
  input  logic        sd_cmd_i,
  output logic        sd_cmd_o,
  output logic        sd_cmd_oe,
  output logic        cmd_inhibit,
  output logic [31:0] resp0_d,
  output logic [31:0] resp1_d,
  output logic [31:0] resp2_d,
  output logic [31:0] resp3_d,
  output logic        resp_we,
  output logic        cmd_complete,
  output logic [3:0]  err_flags
);

  localparam int WCW = $clog2(NCR_MAX + 1);

  sd_state_e      state_q, state_d;
  logic [7:0]     div_q, div_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [3:0]     err_q, err_d;
  logic [15:0]    cmd_q;
  logic [39:0]    tx_sr_q;
  logic [135:0]   rx_sr_q;
  logic [31:0]    resp0_q, resp1_q, resp2_q, resp3_q;
  logic           resp_we_q;

  logic           strb;
  logic           accept;
  logic           rsp136;
  logic [7:0]     rx_last;
  logic           tx_bit;
  logic [2:0]     crc_sel;
  logic [6:0]     crc_tx;
  logic           crc_clr;
  logic           tx_crc_en;
  logic           end_err, idx_err, crc_err;
  logic           unused_bits;

  assign accept  = (state_q == ST_IDLE) && cmd_start && !soft_rst_cmd;
  assign strb    = (div_q == 8'(STB_DIV - 1));
  assign rsp136  = (cmd_q[CMD_RSP_MSB:CMD_RSP_LSB] == RSP_R136);
  assign rx_last = rsp136 ? 8'(R136_BITS - 1) : 8'(R48_BITS - 1);
  assign crc_clr = accept || soft_rst_cmd;

  // Bit strobe divider, realigned to every accepted command.
  always_comb begin
    div_d = div_q + 8'd1;
    if (accept || strb) begin
      div_d = 8'd0;
    end
  end

  // TX bit select: 40 payload bits from the shifter, then CRC7 MSB first
  // (cnt 40..46 has low bits 0..6), then the end bit.
  assign crc_sel = 3'd6 - cnt_q[2:0];
  always_comb begin
    tx_bit = 1'b1;
    if (cnt_q < 8'(TX_CRC_BITS)) begin
      tx_bit = tx_sr_q[39];
    end else if (cnt_q < 8'(TX_BITS - 1)) begin
      tx_bit = crc_tx[crc_sel];
    end
  end

  assign tx_crc_en = (state_q == ST_TX) && strb && (cnt_q < 8'(TX_CRC_BITS));

  sd_crc7 u_crc_tx (
    .clk   (clk),
    .rst_n (ex_resetn),
    .clr_i (crc_clr),
    .en_i  (tx_crc_en),
    .bit_i (tx_sr_q[39]),
    .crc_o (crc_tx)
  );

`ifdef SD_CMD_RESP_CRC_CHK_EN
  logic       rx_crc_en;
  logic [6:0] crc_rx;

  // cnt_q holds (bit number - 1) of the bit being sampled. R48 covers bits
  // 1..40 and R136 bits 9..128; the start bit is 0 and leaves a zero CRC
  // unchanged, so feeding starts with the second bit.
  assign rx_crc_en = (state_q == ST_RX) && strb &&
                     (rsp136 ? ((cnt_q >= 8'd8) && (cnt_q <= 8'd127))
                             : (cnt_q <= 8'd39));

  sd_crc7 u_crc_rx (
    .clk   (clk),
    .rst_n (ex_resetn),
    .clr_i (crc_clr),
    .en_i  (rx_crc_en),
    .bit_i (sd_cmd_i),
    .crc_o (crc_rx)
  );

  assign crc_err     = cmd_q[CMD_CRC_CHK] && (crc_rx != rx_sr_q[7:1]);
  assign unused_bits = ^{rx_sr_q[135:128], cmd_q[15:14], cmd_q[7:5], cmd_q[2]};
`else
  assign crc_err     = 1'b0;
  assign unused_bits = ^{rx_sr_q[135:128], rx_sr_q[7:1], cmd_q[15:14],
                         cmd_q[7:5], cmd_q[2]};
`endif

  assign end_err = ~rx_sr_q[0];
  assign idx_err = cmd_q[CMD_IDX_CHK] && !rsp136 &&
                   (rx_sr_q[45:40] != cmd_q[CMD_IDX_MSB:CMD_IDX_LSB]);

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    if (soft_rst_cmd) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_start) begin
            state_d = ST_TX;
            cnt_d   = '0;
            wcnt_d  = '0;
            err_d   = '0;
          end
        end
        ST_TX: begin
          if (strb) begin
            if (cnt_q == 8'(TX_BITS - 1)) begin
              cnt_d   = '0;
              state_d = (cmd_q[CMD_RSP_MSB:CMD_RSP_LSB] == RSP_NONE) ? ST_DONE : ST_WAIT_RSP;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_WAIT_RSP: begin
          if (strb) begin
            if (!sd_cmd_i) begin
              // The start bit is bit 1 of the response.
              state_d = ST_RX;
              cnt_d   = 8'd1;
            end else if (wcnt_q == WCW'(NCR_MAX - 1)) begin
              state_d  = ST_DONE;
              err_d[0] = 1'b1;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
        ST_RX: begin
          if (strb) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == rx_last) begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          state_d = ST_DONE;
          err_d   = {end_err, idx_err, crc_err, 1'b0};
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      err_q     <= '0;
      cmd_q     <= '0;
      resp_we_q <= 1'b0;
      resp0_q   <= '0;
      resp1_q   <= '0;
      resp2_q   <= '0;
      resp3_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
      resp_we_q <= (state_q == ST_CHECK) && !soft_rst_cmd;
      if (accept) begin
        cmd_q <= cmd_reg;
      end
      if ((state_q == ST_CHECK) && !soft_rst_cmd) begin
        if (rsp136) begin
          {resp3_q, resp2_q, resp1_q, resp0_q} <= {8'h00, rx_sr_q[127:8]};
        end else begin
          resp0_q <= rx_sr_q[39:8];
          resp1_q <= '0;
          resp2_q <= '0;
          resp3_q <= '0;
        end
      end
    end
  end

  // Shift registers: cleared on every new command and on abort.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr_q <= {2'b01, cmd_reg[CMD_IDX_MSB:CMD_IDX_LSB], arg_reg};
    end else if (soft_rst_cmd) begin
      tx_sr_q <= '0;
    end else if ((state_q == ST_TX) && strb) begin
      tx_sr_q <= {tx_sr_q[38:0], 1'b0};
    end
    if (crc_clr) begin
      rx_sr_q <= '0;
    end else if ((state_q == ST_RX) && strb) begin
      rx_sr_q <= {rx_sr_q[134:0], sd_cmd_i};
    end
  end

  assign sd_cmd_oe    = (state_q == ST_TX);
  assign sd_cmd_o     = (state_q == ST_TX) ? tx_bit : 1'b1;
  assign cmd_inhibit  = (state_q != ST_IDLE);
  assign cmd_complete = (state_q == ST_DONE);
  assign err_flags    = (state_q == ST_DONE) ? err_q : 4'b0000;
  assign resp_we      = resp_we_q;
  assign resp0_d      = resp0_q;
  assign resp1_d      = resp1_q;
  assign resp2_d      = resp2_q;
  assign resp3_d      = resp3_q;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// tb_sd_cmd_seq -- self-checking bench for sd_cmd_seq. The bench acts as the
// card: it builds reply frames from field values, drives them on the strobe
// grid, and predicts TX frame, completion time, flags and response words.
// Define SD_CMD_RESP_CRC_CHK_EN consistently for DUT and bench.
module tb_sd_cmd_seq;

  localparam int NCR_MAX = 64;
  localparam int D       = 4;
  localparam int TXB     = 48;
`ifdef SD_CMD_RESP_CRC_CHK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        ex_resetn;
  logic        soft_rst_cmd;
  logic        cmd_start;
  logic [15:0] cmd_reg;
  logic [31:0] arg_reg;
  logic        sd_cmd_i;
  logic        sd_cmd_o;
  logic        sd_cmd_oe;
  logic        cmd_inhibit;
  logic [31:0] resp0_d, resp1_d, resp2_d, resp3_d;
  logic        resp_we;
  logic        cmd_complete;
  logic [3:0]  err_flags;

  int n_tests = 0;
  int n_fail  = 0;

  sd_cmd_seq #(.NCR_MAX(NCR_MAX), .STB_DIV(D)) dut (
    .clk          (clk),
    .ex_resetn    (ex_resetn),
    .soft_rst_cmd (soft_rst_cmd),
    .cmd_start    (cmd_start),
    .cmd_reg      (cmd_reg),
    .arg_reg      (arg_reg),
    .sd_cmd_i     (sd_cmd_i),
    .sd_cmd_o     (sd_cmd_o),
    .sd_cmd_oe    (sd_cmd_oe),
    .cmd_inhibit  (cmd_inhibit),
    .resp0_d      (resp0_d),
    .resp1_d      (resp1_d),
    .resp2_d      (resp2_d),
    .resp3_d      (resp3_d),
    .resp_we      (resp_we),
    .cmd_complete (cmd_complete),
    .err_flags    (err_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 of the n low bits of v, MSB first.
  function automatic logic [6:0] crc7(input logic [127:0] v, input int n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[6] ^ v[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // One full command transaction with the bench playing the card.
  // dly = number of idle strobes before the reply; dly >= NCR_MAX means no reply.
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] typ, input bit ichk, input bit cchk,
                         input int dly, input logic [119:0] pl,
                         input bit bad_idx, input bit bad_crc, input bit bad_end,
                         input bit poke, output logic [47:0] tx_o);
    logic [47:0]  exp_tx, cap;
    logic [135:0] rb;
    logic [39:0]  b40;
    logic [6:0]   c7;
    logic [5:0]   ridx;
    logic [127:0] exp_resp, got_resp;
    logic [3:0]   exp_err, got_err;
    bit           has_rsp;
    int           rlen, rs, exp_c, got_c, n_oe, n_we, m, lim;

    exp_tx   = {2'b01, idx, arg, crc7({88'b0, 2'b01, idx, arg}, 40), 1'b1};
    has_rsp  = (typ != 2'b00) && (dly < NCR_MAX);
    rs       = TXB + 1 + dly;
    rlen     = 0;
    rb       = '1;
    exp_resp = '0;
    if (typ == 2'b01) begin
      rlen = 136;
      c7   = crc7({8'h00, pl}, 120);
      if (bad_crc) c7 = c7 ^ 7'h11;
      rb       = {2'b00, 6'h3F, pl, c7, ~bad_end};
      exp_resp = {8'h00, pl};
    end else if (typ != 2'b00) begin
      rlen = 48;
      ridx = bad_idx ? (idx ^ 6'h2A) : idx;
      b40  = {2'b00, ridx, pl[31:0]};
      c7   = crc7({88'b0, b40}, 40);
      if (bad_crc) c7 = c7 ^ 7'h11;
      rb       = {{88{1'b1}}, b40, c7, ~bad_end};
      exp_resp = {96'b0, pl[31:0]};
    end

    if (typ == 2'b00) begin
      exp_err = 4'b0000;
      exp_c   = TXB * D;
    end else if (!has_rsp) begin
      exp_err = 4'b0001;
      exp_c   = (TXB + NCR_MAX) * D;
    end else begin
      exp_err = {bad_end, ichk && (typ != 2'b01) && bad_idx, CRC_EN && cchk && bad_crc, 1'b0};
      exp_c   = (rs + rlen - 1) * D + 1;
    end

    cap = '0; got_resp = '0; got_err = '0;
    got_c = -1; n_oe = 0; n_we = 0;
    lim = exp_c + 40;

    @(negedge clk);
    cmd_reg   = {2'b00, idx, 3'b000, ichk, cchk, 1'b0, typ};
    arg_reg   = arg;
    cmd_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_start = 1'b0;
    for (int c = 0; c < lim; c++) begin
      if (sd_cmd_oe) begin
        if (n_oe % D == 0) cap = {cap[46:0], sd_cmd_o};
        n_oe++;
      end
      if (resp_we) begin
        n_we++;
        got_resp = {resp3_d, resp2_d, resp1_d, resp0_d};
      end
      if (cmd_complete) begin
        got_c   = c;
        got_err = err_flags;
        break;
      end
      m = (c + D) / D;
      if (has_rsp && (m >= rs) && (m < rs + rlen)) sd_cmd_i = rb[rlen - 1 - (m - rs)];
      else sd_cmd_i = 1'b1;
      cmd_start = poke && has_rsp && (m == rs + 10) && ((c + 1) % D == 0);
      if (cmd_start) cmd_reg = 16'h0000;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_start = 1'b0;
    sd_cmd_i  = 1'b1;

    chk({tag, "/done_cycle"}, 128'(got_c), 128'(exp_c));
    chk({tag, "/err_flags"}, 128'(got_err), 128'(exp_err));
    chk({tag, "/oe_cycles"}, 128'(n_oe), 128'(TXB * D));
    chk({tag, "/tx_frame"}, 128'(cap), 128'(exp_tx));
    chk({tag, "/resp_we_count"}, 128'(n_we), 128'(has_rsp ? 1 : 0));
    if (has_rsp) chk({tag, "/resp"}, got_resp, exp_resp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "/back_to_idle"}, 128'({cmd_complete, resp_we, cmd_inhibit, sd_cmd_oe}), 128'(0));
    tx_o = cap;
  endtask

  initial begin
    logic [47:0]  txf;
    logic [127:0] r;
    logic [1:0]   typ;
    int           dly, n_pulse;

    ex_resetn    = 1'b0;
    soft_rst_cmd = 1'b0;
    cmd_start    = 1'b0;
    cmd_reg      = '0;
    arg_reg      = '0;
    sd_cmd_i     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/ctrl", 128'({sd_cmd_o, sd_cmd_oe, cmd_inhibit, resp_we, cmd_complete, err_flags}),
        128'(9'b1_0000_0000));
    chk("reset/resp", {resp3_d, resp2_d, resp1_d, resp0_d}, 128'(0));
    ex_resetn = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0, no response
    run_cmd("cmd0", 6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 1'b0, txf);
    chk("cmd0/literal_frame", 128'(txf), 128'(48'h40_00000000_95));

    // CMD8, R7 reply echoing 0x1AA
    run_cmd("cmd8", 6'd8, 32'h000001AA, 2'b10, 1'b1, 1'b1, 2, 120'h1AA,
            1'b0, 1'b0, 1'b0, 1'b0, txf);
    chk("cmd8/resp0", 128'(resp0_d), 128'(32'h000001AA));

    // Asynchronous reset in the middle of TX clears everything immediately
    @(negedge clk);
    cmd_reg = 16'h0102; arg_reg = 32'h12345678; cmd_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (10) @(negedge clk);
    ex_resetn = 1'b0;
    #1;
    chk("async_rst/ctrl", 128'({sd_cmd_o, sd_cmd_oe, cmd_inhibit, resp_we, cmd_complete}), 128'(5'b10000));
    chk("async_rst/resp", {resp3_d, resp2_d, resp1_d, resp0_d}, 128'(0));
    @(negedge clk);
    ex_resetn = 1'b1;
    @(negedge clk);

    // Timeout and the last accepted start-bit position
    run_cmd("timeout", 6'd17, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, NCR_MAX, '0,
            1'b0, 1'b0, 1'b0, 1'b0, txf);
    run_cmd("ncr_edge", 6'd55, 32'h0F0F0F0F, 2'b11, 1'b1, 1'b1, NCR_MAX - 1, 120'hCAFEF00D,
            1'b0, 1'b0, 1'b0, 1'b0, txf);

    // Corrupted CRC byte with and without checking enabled
    run_cmd("crc_bad_chk", 6'd13, 32'h00000000, 2'b10, 1'b0, 1'b1, 1, 120'h00FF8000,
            1'b0, 1'b1, 1'b0, 1'b0, txf);
    run_cmd("crc_bad_nochk", 6'd13, 32'h00000000, 2'b10, 1'b0, 1'b0, 1, 120'h00FF8000,
            1'b0, 1'b1, 1'b0, 1'b0, txf);
    // Bad end bit, wrong index (checked and unchecked)
    run_cmd("end_bad", 6'd41, 32'h55AA55AA, 2'b10, 1'b1, 1'b1, 0, 120'h900,
            1'b0, 1'b0, 1'b1, 1'b0, txf);
    run_cmd("idx_bad_chk", 6'd41, 32'h55AA55AA, 2'b11, 1'b1, 1'b1, 5, 120'h901,
            1'b1, 1'b0, 1'b0, 1'b0, txf);
    run_cmd("idx_bad_nochk", 6'd41, 32'h55AA55AA, 2'b10, 1'b0, 1'b1, 5, 120'h902,
            1'b1, 1'b0, 1'b0, 1'b0, txf);

    // 136-bit reply with a cmd_start poked in during RX
    run_cmd("r136", 6'd2, 32'h0, 2'b01, 1'b1, 1'b1, 3, 120'h3F3E3D3C3B3A393837363534333231,
            1'b0, 1'b0, 1'b0, 1'b1, txf);
    chk("r136/resp3_top", 128'(resp3_d[31:24]), 128'(0));

    // Soft command reset at TX bit 20
    @(negedge clk);
    cmd_reg = 16'h1119; arg_reg = 32'hA5A5A5A5; cmd_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (20 * D) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("soft_rst/in_tx", 128'({sd_cmd_oe, cmd_inhibit}), 128'(2'b11));
    soft_rst_cmd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    soft_rst_cmd = 1'b0;
    chk("soft_rst/idle", 128'({sd_cmd_oe, cmd_inhibit, sd_cmd_o}), 128'(3'b001));
    n_pulse = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_complete || resp_we || sd_cmd_oe) n_pulse++;
    end
    chk("soft_rst/no_pulses", 128'(n_pulse), 128'(0));
    run_cmd("after_soft", 6'd17, 32'h00FACE00, 2'b10, 1'b1, 1'b1, 4, 120'h7777,
            1'b0, 1'b0, 1'b0, 1'b0, txf);

    // Randomised transactions
    for (int t = 0; t < 20; t++) begin
      r   = {$urandom, $urandom, $urandom, $urandom};
      typ = 2'($urandom_range(0, 3));
      dly = ($urandom_range(0, 7) == 0) ? NCR_MAX : int'($urandom_range(0, NCR_MAX - 1));
      run_cmd($sformatf("rnd%0d", t), r[5:0], $urandom, typ, r[6], r[7], dly, r[127:8],
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0), r[8], txf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
